// File: rtl/subneg_prog_loader.sv
// subneg_prog_loader
// Receives a framed program image as a byte stream on asynchronous pins and
// writes it into the SUBNEG core's unified memory. The core is held idle
// (core_run=0) until a complete image with a matching checksum is loaded.
//
// Frame: SYNC_BYTE, LEN (1..MEM_WORDS), LEN data bytes, 8-bit sum of data.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   in_data        byte from pins, stable while in_strobe is high
//   in_strobe      asynchronous byte strobe, rising edge = new byte
//   mem_we         one-cycle write pulse to core memory
//   mem_addr       write address
//   mem_wdata      write data
//   core_run       high = core may fetch/execute
//   load_busy      high while a frame is in progress (LEN/DATA/CSUM)
//   load_err       sticky error flag, cleared by a new sync byte
//   byte_count     data words written in the current frame
//
// Optional feature: define SUBNEG_LOADER_TIMEOUT_EN to abort a frame that
// stalls for TIMEOUT_CYCLES clocks between bytes.
module subneg_prog_loader #(
  parameter int          ADDR_W         = 6,
  parameter int          MEM_WORDS      = 22,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_strobe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_run,
  output logic              load_busy,
  output logic              load_err,
  output logic [ADDR_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  // Running image checksum: plain 8-bit sum, wraps mod 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  state_t            state_r;
  logic              strb_meta_r;
  logic              strb_sync_r;
  logic              strb_dly_r;
  logic              byte_ev_s;
  logic              timeout_s;
  logic [7:0]        csum_r;
  logic [ADDR_W-1:0] len_r;
  logic              len_ok_s;

  assign byte_ev_s = strb_sync_r & ~strb_dly_r;
  assign len_ok_s  = (in_data != 8'd0) && (in_data <= 8'(MEM_WORDS));

  // Two-flop synchroniser plus delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      strb_meta_r <= 1'b0;
      strb_sync_r <= 1'b0;
      strb_dly_r  <= 1'b0;
    end else begin
      strb_meta_r <= in_strobe;
      strb_sync_r <= strb_meta_r;
      strb_dly_r  <= strb_sync_r;
    end
  end

`ifdef SUBNEG_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_r;
  logic            in_frame_s;

  assign in_frame_s = (state_r == LEN) || (state_r == DATA) || (state_r == CSUM);
  // Fires on the edge where the counter would reach TIMEOUT_CYCLES.
  assign timeout_s  = in_frame_s && !byte_ev_s && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

  // Inter-byte timer: restarts on every byte, runs only inside a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= '0;
    end else if (byte_ev_s || !in_frame_s) begin
      to_cnt_r <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end
`else
  // No timer: the loader waits indefinitely; the term keeps the parameter referenced.
  assign timeout_s = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 8'd0;
      core_run   <= 1'b0;
      load_busy  <= 1'b0;
      load_err   <= 1'b0;
      byte_count <= '0;
      csum_r     <= 8'd0;
      len_r      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (timeout_s) begin
        state_r   <= ERR;
        load_busy <= 1'b0;
        load_err  <= 1'b1;
        core_run  <= 1'b0;
      end else if (byte_ev_s) begin
        case (state_r)
          IDLE, RUN, ERR: begin
            // Sync byte starts (or restarts) a load; anything else is ignored.
            if (in_data == SYNC_BYTE) begin
              state_r   <= LEN;
              load_busy <= 1'b1;
              load_err  <= 1'b0;
              core_run  <= 1'b0;
            end
          end
          LEN: begin
            if (len_ok_s) begin
              len_r      <= ADDR_W'(in_data);
              byte_count <= '0;
              csum_r     <= 8'd0;
              state_r    <= DATA;
            end else begin
              state_r   <= ERR;
              load_busy <= 1'b0;
              load_err  <= 1'b1;
            end
          end
          DATA: begin
            mem_we     <= 1'b1;
            mem_addr   <= byte_count;
            mem_wdata  <= in_data;
            csum_r     <= csum_add(csum_r, in_data);
            byte_count <= byte_count + ADDR_W'(1);
            if (byte_count + ADDR_W'(1) == len_r) begin
              state_r <= CSUM;
            end
          end
          CSUM: begin
            load_busy <= 1'b0;
            if (in_data == csum_r) begin
              state_r  <= RUN;
              core_run <= 1'b1;
            end else begin
              state_r  <= ERR;
              load_err <= 1'b1;
            end
          end
          default: begin
            state_r   <= IDLE;
            load_busy <= 1'b0;
            core_run  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
